aes_block_framer: RTL and testbench
===================================

# aes_block_framer

Collects the UART receive byte stream into 128-bit plaintext blocks and presents them to the AES core over a valid/ready handshake. Sits between the UART receiver and the AES-128 core. Adds what direct byte counting lacks: resynchronisation by inter-byte timeout, discard on framing error, one block of buffering, and overrun/drop accounting.

## Interface
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUD, 115200: UART bit rate.
- TIMEOUT_BYTES, 4: idle gap, in byte-times of 10 bits each, after which a partial block is discarded.
- clk  in  1  sole clock; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid only when rx_valid=1.
- rx_valid  in  1  single-cycle strobe, one per received byte.
- rx_frame_err  in  1  single-cycle strobe for a bad stop bit.
- blk_data  out  128  assembled block; first received byte in [127:120].
- blk_valid  out  1  block available; held until accepted.
- blk_ready  in  1  consumer accepts the block when blk_valid & blk_ready.
- overrun  out  1  one-cycle pulse when a byte is dropped because no buffer is free.
- timeout  out  1  one-cycle pulse when a partial block is discarded on idle.
- drop_cnt  out  8  count of discarded partial blocks plus overrun bytes; saturates at 255.

## Operation
- Collect buffer: 16 bytes and a 4-bit index idx. Output register: blk_data/blk_valid.
- Collect states:
  - IDLE (idx=0). First byte moves to COLLECT.
  - COLLECT (1≤idx≤15). The 16th byte completes the block.
  - HOLD: a full block is waiting because the output register is occupied.
- Completion: on the 16th byte, the block loads the output register if blk_valid=0 or a handshake occurs in the same cycle. Otherwise it enters HOLD. idx returns to 0 in both cases.
- HOLD exits to IDLE on the first cycle the output register is free, and the held block transfers on that cycle.
- A byte arriving in HOLD is dropped: overrun pulses and drop_cnt increments. The held block is unaffected.
- Frame error in COLLECT: discard the partial block, idx←0, drop_cnt++, go to IDLE. rx_frame_err has priority over a coincident rx_valid, and that byte is not stored.
- Frame error in IDLE or HOLD: ignored.
- Timeout: the idle counter runs only in COLLECT and restarts on every rx_valid.
  - At TIMEOUT_BYTES·10·(CLK_FREQ/BAUD) cycles: discard the partial block, idx←0, timeout pulses, drop_cnt++.
- Coincident rx_valid and timeout expiry: the byte wins. It is stored and the counter restarts.
- drop_cnt increments by at most 1 per cycle.
- blk_data is stable while blk_valid=1.

## Timing
- Reset values: blk_valid=0, blk_data=0, overrun=0, timeout=0, drop_cnt=0, idx=0, state IDLE, idle counter 0.
- Reset mid-block or mid-HOLD discards everything. The first byte after reset release starts a new block.
- Latency: blk_valid rises on the clock edge that samples the 16th rx_valid, so it is visible the following cycle.
- Handshake completes on the edge where blk_valid & blk_ready. blk_valid falls the next cycle unless a completing or held block reloads in that same edge, giving back-to-back blocks with no bubble.
- blk_ready asserted while blk_valid=0 has no effect.
- Sustained-rate throughput is bounded by the UART, not by this block.

## Structure
- Shared package aes_uart_pkg:
  - BLOCK_BYTES=16.
  - clks_per_bit(CLK_FREQ,BAUD) function.
  - Collect-state enum {IDLE, COLLECT, HOLD}.
- Sub-module aes_idle_timer: loadable down-counter with enable, restart, and one-cycle expire outputs.
- Everything else lives in aes_block_framer.

## Test plan
Use CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10, timeout=400 cycles).
- Send bytes 00,11,…,ff with blk_ready=1 -> one blk_valid pulse with blk_data=128'h00112233445566778899aabbccddeeff, one cycle after the 16th rx_valid.
- Send 5 bytes, idle 400 cycles, then send 16 bytes 0x01..0x10 -> timeout pulses once and drop_cnt=1. blk_data=128'h0102…0f10.
- Hold blk_ready=0 and send 3 full blocks A, B, C. The first byte of C causes an overrun, and drop_cnt then counts every C byte (16). Release blk_ready -> A is delivered, then B on the next cycle. C is never delivered.
- Assert rx_frame_err together with rx_valid on byte 8 -> partial block discarded, drop_cnt=1. The next 16 bytes form a clean block.
- rx_valid on exactly cycle 400 of the idle count -> no timeout, byte stored, block completes normally.
- Assert rst during byte 10, then send 16 bytes -> all outputs 0 during reset. A single correct block follows, and drop_cnt=0.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared definitions for the UART-to-AES path.
// Contents: block size, byte-time length in bit periods, the collect-state
// enum used by the block framer, and a helper that derives clocks per UART bit.
package aes_uart_pkg;

    localparam int unsigned BLOCK_BYTES        = 16;
    localparam int unsigned IDX_W              = $clog2(BLOCK_BYTES);
    // One UART character: start + 8 data + stop.
    localparam int unsigned BITS_PER_BYTE_TIME = 10;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } collect_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/aes_idle_timer.sv
// Loadable idle down-counter.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   enable      counter decrements while high
//   restart     reload the counter with load_value (wins over enable)
//   load_value  reload value; expire fires load_value cycles after a restart
//   expire      high for the single cycle in which the count runs out
module aes_idle_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = load_value;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires while the count sits at 1, so the owner acts on the edge that
    // would take it to 0; the counter then parks at 0 and cannot re-fire.
    assign expire = enable && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/aes_block_framer.sv
// Assembles the UART receive byte stream into 128-bit blocks for the AES core.
// A partial block is thrown away on a framing error or an inter-byte idle
// timeout; one completed block can wait in the collect buffer while the
// output register is occupied, and bytes arriving then are dropped.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   rx_data       received byte, qualified by rx_valid
//   rx_valid      one-cycle strobe per received byte
//   rx_frame_err  one-cycle strobe for a bad stop bit
//   blk_data      assembled block, first byte in [127:120]
//   blk_valid     block available, held until blk_ready
//   blk_ready     consumer accept
//   overrun       one-cycle pulse when a byte is dropped for lack of buffer
//   timeout       one-cycle pulse when a partial block is discarded on idle
//   drop_cnt      discarded partial blocks plus overrun bytes, saturating
module aes_block_framer
    import aes_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50000000,
    parameter int unsigned BAUD          = 115200,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    input  logic         rx_frame_err,
    output logic [127:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         overrun,
    output logic         timeout,
    output logic [7:0]   drop_cnt
);

    localparam int unsigned BLK_W          = 8 * BLOCK_BYTES;
    localparam int unsigned CLKS_PER_BIT   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_BYTES * BITS_PER_BYTE_TIME * CLKS_PER_BIT;
    localparam int unsigned TIMER_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST     = IDX_W'(BLOCK_BYTES - 1);

    collect_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    // Shift register: after BLOCK_BYTES shifts the first byte sits at the top.
    logic [BLK_W-1:0] buf_q, buf_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       drop_q, drop_d;

    logic             drop_inc;
    logic             timer_restart;
    logic             timer_expire;
    logic             out_free;
    logic [BLK_W-1:0] buf_shift;

    aes_idle_timer #(
        .WIDTH (TIMER_W)
    ) u_idle_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (state_q == COLLECT),
        .restart    (timer_restart),
        .load_value (TIMEOUT_LOAD),
        .expire     (timer_expire)
    );

    // Output register can take a new block this edge: empty, or being drained.
    assign out_free  = !valid_q || blk_ready;
    assign buf_shift = {buf_q[BLK_W-9:0], rx_data};

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        data_d        = data_q;
        valid_d       = valid_q && !blk_ready;
        overrun_d     = 1'b0;
        timeout_d     = 1'b0;
        drop_inc      = 1'b0;
        timer_restart = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A frame error here has no partial block to discard.
                if (rx_valid) begin
                    buf_d         = buf_shift;
                    idx_d         = IDX_W'(1);
                    state_d       = COLLECT;
                    timer_restart = 1'b1;
                end
            end

            COLLECT: begin
                if (rx_frame_err) begin
                    idx_d    = '0;
                    state_d  = IDLE;
                    drop_inc = 1'b1;
                end else if (rx_valid) begin
                    // A byte coincident with timer expiry is kept.
                    timer_restart = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (out_free) begin
                            data_d  = buf_shift;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            buf_d   = buf_shift;
                            state_d = HOLD;
                        end
                    end else begin
                        buf_d = buf_shift;
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timer_expire) begin
                    idx_d     = '0;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    drop_inc  = 1'b1;
                end
            end

            HOLD: begin
                if (out_free) begin
                    data_d  = buf_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                // Any byte seen while a full block waits is lost.
                if (rx_valid) begin
                    overrun_d = 1'b1;
                    drop_inc  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        drop_d = drop_q;
        if (drop_inc && (drop_q != 8'hff)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            buf_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    assign blk_data  = data_q;
    assign blk_valid = valid_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_aes_block_framer.sv
module tb_aes_block_framer;

    logic         clk;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_frame_err;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic         overrun;
    logic         timeout;
    logic [7:0]   drop_cnt;

    aes_block_framer #(
        .CLK_FREQ      (1000000),
        .BAUD          (100000),
        .TIMEOUT_BYTES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .blk_data     (blk_data),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .overrun      (overrun),
        .timeout      (timeout),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int delivered      = 0;
    int timeout_pulses = 0;
    int overrun_pulses = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (timeout === 1'b1) timeout_pulses++;
            if (overrun === 1'b1) overrun_pulses++;
            if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
                check("sb_block_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    check("blk_data", blk_data, exp_q.pop_front());
                    delivered++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [127:0] make_block(input logic [7:0] start, input logic [7:0] step);
        logic [127:0] blk;
        logic [7:0]   v;
        v = start;
        for (int i = 0; i < 16; i++) begin
            blk[127-8*i -: 8] = v;
            v = v + step;
        end
        return blk;
    endfunction

    // One idle cycle between bytes; none after the last so latency is checkable.
    task automatic send_block(input logic [127:0] blk);
        for (int i = 0; i < 16; i++) begin
            send_byte(blk[127-8*i -: 8]);
            if (i != 15) tick();
        end
    endtask

    logic [127:0] blk_a, blk_b, blk_c, blk_t;
    int t_snap, o_snap;

    initial begin
        rst          = 1'b1;
        rx_data      = '0;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        blk_ready    = 1'b0;
        tick();
        tick();
        check("rst_blk_valid", 128'(blk_valid), 128'd0);
        check("rst_blk_data",  blk_data, 128'd0);
        check("rst_overrun",   128'(overrun), 128'd0);
        check("rst_timeout",   128'(timeout), 128'd0);
        check("rst_drop_cnt",  128'(drop_cnt), 128'd0);
        rst = 1'b0;
        tick();

        // Basic block, ready held high.
        blk_ready = 1'b1;
        blk_t = make_block(8'h00, 8'h11);
        check("pattern_t1", blk_t, 128'h00112233445566778899aabbccddeeff);
        exp_q.push_back(blk_t);
        send_block(blk_t);
        check("t1_latency_valid", 128'(blk_valid), 128'd1);
        tick();
        check("t1_valid_falls", 128'(blk_valid), 128'd0);
        check("t1_drop_cnt", 128'(drop_cnt), 128'd0);

        // Idle timeout after 5 bytes, exact expiry cycle.
        t_snap = timeout_pulses;
        for (int i = 0; i < 5; i++) begin
            send_byte(8'he0 + 8'(i));
            tick();
        end
        // The loop's trailing tick counts as idle cycle 1.
        repeat (398) tick();
        check("t2_timeout_not_early", 128'(timeout), 128'd0);
        tick();
        check("t2_timeout_pulse", 128'(timeout), 128'd1);
        check("t2_drop_cnt", 128'(drop_cnt), 128'd1);
        tick();
        check("t2_timeout_one_cycle", 128'(timeout), 128'd0);
        blk_t = make_block(8'h01, 8'h01);
        exp_q.push_back(blk_t);
        send_block(blk_t);
        tick();
        check("t2_timeout_count", 128'(timeout_pulses - t_snap), 128'd1);
        check("t2_drop_cnt_after", 128'(drop_cnt), 128'd1);

        // Overrun: A in output, B held, C dropped byte by byte.
        blk_ready = 1'b0;
        o_snap = overrun_pulses;
        blk_a = make_block(8'h20, 8'h01);
        blk_b = make_block(8'h40, 8'h01);
        blk_c = make_block(8'h60, 8'h01);
        exp_q.push_back(blk_a);
        exp_q.push_back(blk_b);
        send_block(blk_a);
        tick();
        send_block(blk_b);
        tick();
        check("t3_no_overrun_before_c", 128'(overrun_pulses - o_snap), 128'd0);
        send_block(blk_c);
        tick();
        check("t3_overrun_count", 128'(overrun_pulses - o_snap), 128'd16);
        check("t3_drop_cnt", 128'(drop_cnt), 128'd17);
        check("t3_valid_held", 128'(blk_valid), 128'd1);
        check("t3_data_stable_a", blk_data, blk_a);
        blk_ready = 1'b1;
        tick();
        check("t3_b_no_bubble_valid", 128'(blk_valid), 128'd1);
        check("t3_b_no_bubble_data", blk_data, blk_b);
        tick();
        check("t3_valid_falls", 128'(blk_valid), 128'd0);
        repeat (3) tick();
        check("t3_c_not_delivered", 128'(delivered), 128'd4);

        // Frame error coincident with byte 8.
        for (int i = 0; i < 7; i++) begin
            send_byte(8'hd0 + 8'(i));
            tick();
        end
        rx_frame_err = 1'b1;
        send_byte(8'hd7);
        rx_frame_err = 1'b0;
        check("t4_drop_cnt", 128'(drop_cnt), 128'd18);
        tick();
        blk_t = make_block(8'h80, 8'h03);
        exp_q.push_back(blk_t);
        send_block(blk_t);
        check("t4_clean_valid", 128'(blk_valid), 128'd1);
        tick();
        check("t4_delivered", 128'(delivered), 128'd5);

        // Byte lands exactly on the expiry cycle: byte wins.
        t_snap = timeout_pulses;
        blk_t = make_block(8'hc0, 8'h01);
        exp_q.push_back(blk_t);
        for (int i = 0; i < 15; i++) begin
            send_byte(blk_t[127-8*i -: 8]);
            if (i != 14) tick();
        end
        repeat (399) tick();
        send_byte(blk_t[7:0]);
        check("t5_valid", 128'(blk_valid), 128'd1);
        check("t5_no_timeout", 128'(timeout), 128'd0);
        check("t5_drop_cnt", 128'(drop_cnt), 128'd18);
        tick();
        tick();
        check("t5_timeout_count", 128'(timeout_pulses - t_snap), 128'd0);

        // Reset during byte 10.
        for (int i = 0; i < 9; i++) begin
            send_byte(8'hf0 + 8'(i));
            tick();
        end
        rx_data  = 8'hf9;
        rx_valid = 1'b1;
        rst      = 1'b1;
        #1;
        check("t6_rst_blk_data",  blk_data, 128'd0);
        check("t6_rst_drop_cnt",  128'(drop_cnt), 128'd0);
        check("t6_rst_blk_valid", 128'(blk_valid), 128'd0);
        tick();
        rx_valid = 1'b0;
        tick();
        check("t6_rst_overrun", 128'(overrun), 128'd0);
        check("t6_rst_timeout", 128'(timeout), 128'd0);
        rst = 1'b0;
        tick();
        blk_t = make_block(8'h5a, 8'h07);
        exp_q.push_back(blk_t);
        send_block(blk_t);
        check("t6_valid", 128'(blk_valid), 128'd1);
        tick();
        tick();
        check("t6_drop_cnt", 128'(drop_cnt), 128'd0);

        check("final_delivered", 128'(delivered), 128'd7);
        check("final_sb_empty", 128'(exp_q.size()), 128'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
